arrow_scheduler: RTL and testbench

Sequencer for the four-lane arrow datapath. It owns the per-lane arrow state: spawns arrows, scrolls them upward once per frame, judges player hits against a target window, and retires missed arrows. It drives the packed arrow_y bus consumed by the arrow drawing block. It also runs a small game FSM (IDLE/RUN/DONE) with score and miss counters. It sits in the pixel-clock domain between the input/pattern logic and the drawing/colour path.

---
 rtl/arrow_pkg.sv | 19 +
 rtl/arrow_lane.sv | 73 +++++++
 rtl/arrow_scheduler.sv | 118 +++++++++++
 tb/tb_arrow_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// Shared types for the arrow scheduler: game state encoding and the per-lane
// register layout.
package arrow_pkg;

  localparam int DEF_CORDW       = 10;
  localparam int DEF_ARROW_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                 active;
    logic [DEF_CORDW-1:0] y;
  } lane_t;

endpackage

// File: rtl/arrow_lane.sv
// One arrow lane: holds the arrow position, judges presses against the hit
// window and scrolls/retires the arrow on frame ticks.
module arrow_lane
  import arrow_pkg::*;
#(
  parameter int SPAWN_Y     = 480,
  parameter int OFFSCREEN_Y = 1000,
  parameter int SPEED       = 2,
  parameter int TARGET_Y    = 40,
  parameter int HIT_WIN     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 spawn,
  input  logic                 hit,
  input  logic                 frame,
  output logic [DEF_CORDW-1:0] y,
  output logic                 active,
  output logic                 hit_evt,
  output logic                 miss_evt
);

  localparam logic [DEF_CORDW-1:0] SPAWN_V = DEF_CORDW'(SPAWN_Y);
  localparam logic [DEF_CORDW-1:0] OFF_V   = DEF_CORDW'(OFFSCREEN_Y);
  localparam logic [DEF_CORDW-1:0] SPEED_V = DEF_CORDW'(SPEED);
  localparam logic [DEF_CORDW-1:0] WIN_LO  = DEF_CORDW'(TARGET_Y);
  localparam logic [DEF_CORDW-1:0] WIN_HI  = DEF_CORDW'(TARGET_Y + HIT_WIN);

  lane_t q, d;
  logic  in_win;

  assign in_win = (q.y >= WIN_LO) && (q.y <= WIN_HI);

  always_comb begin
    // NOTE: defaults first so every path assigns d and the pulses; no latch.
    d        = q;
    hit_evt  = 1'b0;
    miss_evt = 1'b0;
    if (clear) begin
      d = '{active: 1'b0, y: OFF_V};
    end else if (en) begin
      if (hit && q.active && in_win) begin
        d        = '{active: 1'b0, y: OFF_V};
        hit_evt  = 1'b1;
      end else begin
        // A bad press counts as a miss but the arrow keeps scrolling.
        if (hit && q.active) miss_evt = 1'b1;
        if (!q.active) begin
          if (spawn && !hit) d = '{active: 1'b1, y: SPAWN_V};
        end else if (frame) begin
          if (q.y >= SPEED_V) begin
            d.y = q.y - SPEED_V;
          end else begin
            d        = '{active: 1'b0, y: OFF_V};
            miss_evt = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: non-blocking so every lane and counter sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) q <= '{active: 1'b0, y: OFF_V};
    else         q <= d;
  end

  assign y      = q.y;
  assign active = q.active;

endmodule

// File: rtl/arrow_scheduler.sv
// Arrow sequencer: per-lane arrow state plus the IDLE/RUN/DONE game FSM with
// saturating score and miss counters.
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int CORDW       = DEF_CORDW,
  parameter int ARROW_COUNT = DEF_ARROW_COUNT,
  parameter int SPAWN_Y     = 480,
  parameter int OFFSCREEN_Y = 1000,
  parameter int SPEED       = 2,
  parameter int TARGET_Y    = 40,
  parameter int HIT_WIN     = 8,
  parameter int MISS_LIMIT  = 3,
  parameter int SCOREW      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         frame_i,
  input  logic [ARROW_COUNT-1:0]       spawn_i,
  input  logic [ARROW_COUNT-1:0]       hit_i,
  output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
  output logic [ARROW_COUNT-1:0]       active_o,
  output logic [ARROW_COUNT-1:0]       hit_o,
  output logic [ARROW_COUNT-1:0]       miss_o,
  output logic [SCOREW-1:0]            score_o,
  output logic [1:0]                   miss_cnt_o,
  output logic                         running_o,
  output logic                         done_o
);

  state_t                 state, state_nxt;
  logic                   lanes_en, lanes_clear;
  logic [ARROW_COUNT-1:0] hit_evt, miss_evt;
  logic [SCOREW:0]        score_sum;
  logic [SCOREW-1:0]      score_nxt;
  logic [1:0]             miss_nxt;
  int                     hit_n, miss_n, miss_total;

  assign lanes_en    = (state == ST_RUN);
  // Starting from IDLE or DONE wipes any frozen arrows in the same edge.
  assign lanes_clear = start_i && (state != ST_RUN);

  for (genvar k = 0; k < ARROW_COUNT; k++) begin : g_lane
    arrow_lane #(
      .SPAWN_Y    (SPAWN_Y),
      .OFFSCREEN_Y(OFFSCREEN_Y),
      .SPEED      (SPEED),
      .TARGET_Y   (TARGET_Y),
      .HIT_WIN    (HIT_WIN)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear   (lanes_clear),
      .en      (lanes_en),
      .spawn   (spawn_i[k]),
      .hit     (hit_i[k]),
      .frame   (frame_i),
      .y       (arrow_y_o[CORDW*k +: CORDW]),
      .active  (active_o[k]),
      .hit_evt (hit_evt[k]),
      .miss_evt(miss_evt[k])
    );
  end

  always_comb begin
    hit_n  = 0;
    miss_n = 0;
    for (int k = 0; k < ARROW_COUNT; k++) begin
      hit_n  += int'(hit_evt[k]);
      miss_n += int'(miss_evt[k]);
    end
    score_sum  = {1'b0, score_o} + (SCOREW+1)'(hit_n);
    score_nxt  = score_sum[SCOREW] ? '1 : score_sum[SCOREW-1:0];
    miss_total = int'(miss_cnt_o) + miss_n;
    miss_nxt   = (miss_total >= 3) ? 2'd3 : miss_total[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_RUN;
      ST_RUN:  if (int'(miss_nxt) >= MISS_LIMIT) state_nxt = ST_DONE;
      ST_DONE: if (start_i) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    running_o = (state == ST_RUN);
    done_o    = (state == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_o      <= '0;
      miss_o     <= '0;
      score_o    <= '0;
      miss_cnt_o <= '0;
    end else begin
      hit_o  <= hit_evt;
      miss_o <= miss_evt;
      if (lanes_clear) begin
        score_o    <= '0;
        miss_cnt_o <= '0;
      end else if (state == ST_RUN) begin
        score_o    <= score_nxt;
        miss_cnt_o <= miss_nxt;
      end
    end
  end

endmodule

// File: tb/tb_arrow_scheduler.sv
// Self-checking bench for arrow_scheduler: reference model feeding a scoreboard,
// vector tables for IDLE/DONE behaviour and hand sequences for scrolling.
module tb_arrow_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, frame_i;
  logic [3:0]  spawn_i, hit_i;
  logic [39:0] arrow_y_o;
  logic [3:0]  active_o, hit_o, miss_o;
  logic [15:0] score_o;
  logic [1:0]  miss_cnt_o;
  logic        running_o, done_o;

  arrow_scheduler dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .frame_i   (frame_i),
    .spawn_i   (spawn_i),
    .hit_i     (hit_i),
    .arrow_y_o (arrow_y_o),
    .active_o  (active_o),
    .hit_o     (hit_o),
    .miss_o    (miss_o),
    .score_o   (score_o),
    .miss_cnt_o(miss_cnt_o),
    .running_o (running_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [39:0] y;
    logic [3:0]  active, hit, miss;
    logic [15:0] score;
    logic [1:0]  miss_cnt;
    logic        running, done;
  } out_t;

  typedef struct packed {
    logic       start, frame;
    logic [3:0] spawn, hit;
    logic [3:0] exp_active, exp_hit, exp_miss;
    logic       exp_running, exp_done;
    logic [1:0] exp_miss_cnt;
  } vec_t;

  int   n_checks = 0, n_errors = 0;
  out_t exp_q[$];

  // Reference model state
  int   m_state;  // 0 idle, 1 run, 2 done
  bit   m_act[4];
  int   m_y[4];
  int   m_score, m_miss;
  out_t m_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] lane_y(input int k);
    return arrow_y_o[10*k +: 10];
  endfunction

  task automatic model_step(input logic r, input logic s, input logic f,
                            input logic [3:0] sp, input logic [3:0] h);
    int nh, nm;
    m_out.hit  = '0;
    m_out.miss = '0;
    if (!r) begin
      m_state = 0; m_score = 0; m_miss = 0;
      for (int k = 0; k < 4; k++) begin m_act[k] = 0; m_y[k] = 1000; end
    end else if (m_state == 1) begin
      nh = 0; nm = 0;
      for (int k = 0; k < 4; k++) begin
        if (h[k] && m_act[k] && m_y[k] >= 40 && m_y[k] <= 48) begin
          m_out.hit[k] = 1'b1; m_act[k] = 0; m_y[k] = 1000; nh++;
        end else begin
          if (h[k] && m_act[k]) m_out.miss[k] = 1'b1;
          if (!m_act[k]) begin
            if (sp[k] && !h[k]) begin m_act[k] = 1; m_y[k] = 480; end
          end else if (f) begin
            if (m_y[k] >= 2) m_y[k] -= 2;
            else begin m_act[k] = 0; m_y[k] = 1000; m_out.miss[k] = 1'b1; end
          end
          if (m_out.miss[k]) nm++;
        end
      end
      m_score = (m_score + nh > 65535) ? 65535 : m_score + nh;
      m_miss  = (m_miss + nm > 3) ? 3 : m_miss + nm;
      if (m_miss >= 3) m_state = 2;
    end else if (s) begin
      m_state = 1; m_score = 0; m_miss = 0;
      for (int k = 0; k < 4; k++) begin m_act[k] = 0; m_y[k] = 1000; end
    end
    for (int k = 0; k < 4; k++) begin
      m_out.y[10*k +: 10] = 10'(m_y[k]);
      m_out.active[k]     = m_act[k];
    end
    m_out.score    = 16'(m_score);
    m_out.miss_cnt = 2'(m_miss);
    m_out.running  = (m_state == 1);
    m_out.done     = (m_state == 2);
  endtask

  // One clock: drive on the falling edge, push the model's expectation, then
  // compare against the DUT just after the rising edge.
  task automatic cycle(input logic r, input logic s, input logic f,
                       input logic [3:0] sp, input logic [3:0] h);
    out_t e;
    @(negedge clk_i);
    rst_ni = r; start_i = s; frame_i = f; spawn_i = sp; hit_i = h;
    model_step(r, s, f, sp, h);
    exp_q.push_back(m_out);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    check("sb_arrow_y", 64'(arrow_y_o), 64'(e.y));
    check("sb_flags", 64'({active_o, hit_o, miss_o, running_o, done_o}),
          64'({e.active, e.hit, e.miss, e.running, e.done}));
    check("sb_counters", 64'({score_o, miss_cnt_o}), 64'({e.score, e.miss_cnt}));
    start_i = 1'b0; frame_i = 1'b0; spawn_i = '0; hit_i = '0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    cycle(1'b1, v.start, v.frame, v.spawn, v.hit);
    check({tag, "_active"}, 64'(active_o), 64'(v.exp_active));
    check({tag, "_pulses"}, 64'({hit_o, miss_o}), 64'({v.exp_hit, v.exp_miss}));
    check({tag, "_fsm"}, 64'({running_o, done_o, miss_cnt_o}),
          64'({v.exp_running, v.exp_done, v.exp_miss_cnt}));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec_idle[3];
    vec_t vec_done[4];

    vec_idle[0] = '{start:1'b0, frame:1'b0, spawn:4'b0001, hit:4'b0000, exp_active:4'b0000,
                    exp_hit:4'b0, exp_miss:4'b0, exp_running:1'b0, exp_done:1'b0, exp_miss_cnt:2'd0};
    vec_idle[1] = '{start:1'b1, frame:1'b0, spawn:4'b0000, hit:4'b0000, exp_active:4'b0000,
                    exp_hit:4'b0, exp_miss:4'b0, exp_running:1'b1, exp_done:1'b0, exp_miss_cnt:2'd0};
    vec_idle[2] = '{start:1'b0, frame:1'b0, spawn:4'b0001, hit:4'b0000, exp_active:4'b0001,
                    exp_hit:4'b0, exp_miss:4'b0, exp_running:1'b1, exp_done:1'b0, exp_miss_cnt:2'd0};

    vec_done[0] = '{start:1'b0, frame:1'b1, spawn:4'b1111, hit:4'b1111, exp_active:4'b0010,
                    exp_hit:4'b0, exp_miss:4'b0, exp_running:1'b0, exp_done:1'b1, exp_miss_cnt:2'd3};
    vec_done[1] = '{start:1'b0, frame:1'b0, spawn:4'b0000, hit:4'b0010, exp_active:4'b0010,
                    exp_hit:4'b0, exp_miss:4'b0, exp_running:1'b0, exp_done:1'b1, exp_miss_cnt:2'd3};
    vec_done[2] = '{start:1'b0, frame:1'b1, spawn:4'b0000, hit:4'b0000, exp_active:4'b0010,
                    exp_hit:4'b0, exp_miss:4'b0, exp_running:1'b0, exp_done:1'b1, exp_miss_cnt:2'd3};
    vec_done[3] = '{start:1'b1, frame:1'b0, spawn:4'b0000, hit:4'b0000, exp_active:4'b0000,
                    exp_hit:4'b0, exp_miss:4'b0, exp_running:1'b1, exp_done:1'b0, exp_miss_cnt:2'd0};

    rst_ni = 1'b0; start_i = 1'b0; frame_i = 1'b0; spawn_i = '0; hit_i = '0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    check("reset_y", 64'(arrow_y_o), 64'({4{10'd1000}}));
    check("reset_flags", 64'({active_o, hit_o, miss_o, running_o, done_o}), 64'd0);
    check("reset_counters", 64'({score_o, miss_cnt_o}), 64'd0);

    // Spawn ignored in IDLE, start, first spawn
    for (int i = 0; i < 3; i++) apply_vec(vec_idle[i], $sformatf("idle_vec%0d", i));
    check("spawn_lane0_y", 64'(lane_y(0)), 64'd480);
    check("spawn_other_y", 64'({lane_y(3), lane_y(2), lane_y(1)}), 64'({3{10'd1000}}));

    // Scroll to the window floor and hit
    frames(220);
    check("scroll_lane0_y40", 64'(lane_y(0)), 64'd40);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001);
    check("hit_low_pulse", 64'(hit_o), 64'b0001);
    check("hit_low_score", 64'(score_o), 64'd1);
    check("hit_low_clear", 64'({active_o, lane_y(0)}), 64'({4'b0000, 10'd1000}));

    // Window ceiling y=48 is still a hit
    cycle(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000);
    frames(216);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001);
    check("hit_high_pulse", 64'({hit_o, score_o}), 64'({4'b0001, 16'd2}));

    // Bad press at y=100: miss, arrow keeps scrolling
    cycle(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000);
    frames(190);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010);
    check("bad_press_miss", 64'({miss_o, miss_cnt_o, active_o}), 64'({4'b0010, 2'd1, 4'b0010}));
    frames(1);
    check("bad_press_scroll", 64'(lane_y(1)), 64'd98);
    frames(25);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010);
    check("lane1_hit", 64'({hit_o, score_o}), 64'({4'b0010, 16'd3}));

    // Three lanes retire together; lane 1 trails by one frame
    cycle(1'b1, 1'b0, 1'b0, 4'b1101, 4'b0000);
    frames(1);
    cycle(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000);
    frames(238);
    check("y2_boundary", 64'({lane_y(0), active_o}), 64'({10'd2, 4'b1111}));
    frames(1);
    check("y0_still_active", 64'({lane_y(0), lane_y(1), active_o, miss_o}),
          64'({10'd0, 10'd2, 4'b1111, 4'b0000}));
    frames(1);
    check("retire_miss", 64'({miss_o, miss_cnt_o, done_o}), 64'({4'b1101, 2'd3, 1'b1}));
    check("retire_frozen_lane1", 64'({lane_y(1), active_o}), 64'({10'd0, 4'b0010}));

    // DONE ignores spawn/hit/frame; start restarts
    for (int i = 0; i < 4; i++) apply_vec(vec_done[i], $sformatf("done_vec%0d", i));
    check("restart_y", 64'(arrow_y_o), 64'({4{10'd1000}}));
    check("restart_score", 64'(score_o), 64'd0);

    // Spawn+frame on active lane, hit+frame judged on pre-update y
    cycle(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000);
    frames(78);
    cycle(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000);
    frames(140);
    check("pre_lane_y", 64'({lane_y(3), lane_y(2)}), 64'({10'd44, 10'd200}));
    cycle(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001);
    check("inactive_hit_spawn", 64'({active_o, hit_o, miss_o}), 64'({4'b1100, 8'd0}));
    cycle(1'b1, 1'b0, 1'b1, 4'b0100, 4'b1000);
    check("spawn_frame_y", 64'(lane_y(2)), 64'd198);
    check("hit_frame_judge", 64'({hit_o, active_o, score_o}), 64'({4'b1000, 4'b0100, 16'd1}));

    // Build up score 5 with four lanes in flight, then reset
    cycle(1'b1, 1'b0, 1'b0, 4'b1011, 4'b0000);
    frames(75);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100);
    frames(141);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1011);
    check("multi_hit", 64'({hit_o, score_o}), 64'({4'b1011, 16'd5}));
    cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000);
    check("four_active", 64'({active_o, score_o}), 64'({4'b1111, 16'd5}));
    cycle(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    check("midrun_reset_y", 64'(arrow_y_o), 64'({4{10'd1000}}));
    check("midrun_reset_rest", 64'({active_o, hit_o, miss_o, score_o, miss_cnt_o, running_o, done_o}),
          64'd0);
    cycle(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000);
    check("post_reset_idle", 64'({active_o, running_o}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
